// File: rtl/food_spawner.sv
// Food spawner: requests random words, maps them onto the play grid and rejects out-of-range or occupied cells.
// Optional exhaustive grid scan after MAX_TRIES misses when FOOD_SPAWNER_SCAN_FALLBACK_EN is defined.
module food_spawner #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int X_BITS    = 6,
    parameter int Y_BITS    = 5,
    parameter int MAX_TRIES = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Spawn,
    output logic              o_RandNeed,
    input  logic [13:0]       i_RandNum,
    input  logic              i_isRanDone,
    output logic [X_BITS-1:0] o_OccX,
    output logic [Y_BITS-1:0] o_OccY,
    input  logic              i_Occupied,
    output logic [X_BITS-1:0] o_FoodX,
    output logic [Y_BITS-1:0] o_FoodY,
    output logic              o_FoodValid,
    output logic              o_Fail,
    output logic              o_Busy
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [X_BITS-1:0] X_MAX  = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] Y_MAX  = Y_BITS'(GRID_H - 1);
    localparam logic [TW-1:0]     T_LAST = TW'(MAX_TRIES - 1);

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        WAIT_RN,
        CHECK,
        EVAL,
        RETRY,
        DONE,
        GIVEUP
`ifdef FOOD_SPAWNER_SCAN_FALLBACK_EN
        , SCAN
`endif
    } state_t;

    state_t state, state_nxt;

    logic [TW-1:0]     tries;
    logic [X_BITS-1:0] cx;
    logic [Y_BITS-1:0] cy;
    logic [X_BITS-1:0] rx;
    logic [Y_BITS-1:0] ry;
    logic              in_range;
    logic              unused_rand;

`ifdef FOOD_SPAWNER_SCAN_FALLBACK_EN
    localparam int SW = $clog2(GRID_W * GRID_H);
    localparam logic [SW-1:0] S_LAST = SW'(GRID_W * GRID_H - 1);
    logic [SW-1:0] scan_cnt;
    logic          scanning;
    logic          have_cand;
`endif

    assign rx          = i_RandNum[X_BITS-1:0];
    assign ry          = i_RandNum[X_BITS+Y_BITS-1:X_BITS];
    assign in_range    = (rx <= X_MAX) && (ry <= Y_MAX);
    assign unused_rand = ^i_RandNum;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_Spawn) state_nxt = REQ;
            REQ:     state_nxt = WAIT_RN;
            WAIT_RN: if (i_isRanDone) state_nxt = in_range ? CHECK : RETRY;
            CHECK:   state_nxt = EVAL;
            EVAL: begin
                if (!i_Occupied) state_nxt = DONE;
`ifdef FOOD_SPAWNER_SCAN_FALLBACK_EN
                else if (scanning) state_nxt = (scan_cnt == S_LAST) ? GIVEUP : CHECK;
`endif
                else state_nxt = RETRY;
            end
            RETRY: begin
                if (tries == T_LAST) begin
`ifdef FOOD_SPAWNER_SCAN_FALLBACK_EN
                    state_nxt = SCAN;
`else
                    state_nxt = GIVEUP;
`endif
                end else begin
                    state_nxt = REQ;
                end
            end
`ifdef FOOD_SPAWNER_SCAN_FALLBACK_EN
            SCAN:    state_nxt = CHECK;
`endif
            DONE:    state_nxt = IDLE;
            GIVEUP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cx/cy only take in-range candidates, so they always hold the last one a scan would start from.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            tries   <= '0;
            cx      <= '0;
            cy      <= '0;
            o_FoodX <= '0;
            o_FoodY <= '0;
`ifdef FOOD_SPAWNER_SCAN_FALLBACK_EN
            scan_cnt  <= '0;
            scanning  <= 1'b0;
            have_cand <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (i_Spawn) begin
                    tries <= '0;
`ifdef FOOD_SPAWNER_SCAN_FALLBACK_EN
                    scanning  <= 1'b0;
                    have_cand <= 1'b0;
`endif
                end
                WAIT_RN: if (i_isRanDone && in_range) begin
                    cx <= rx;
                    cy <= ry;
`ifdef FOOD_SPAWNER_SCAN_FALLBACK_EN
                    have_cand <= 1'b1;
`endif
                end
                EVAL: begin
                    if (!i_Occupied) begin
                        o_FoodX <= cx;
                        o_FoodY <= cy;
                    end
`ifdef FOOD_SPAWNER_SCAN_FALLBACK_EN
                    else if (scanning) begin
                        scan_cnt <= scan_cnt + SW'(1);
                        if (cx == X_MAX) begin
                            cx <= '0;
                            cy <= (cy == Y_MAX) ? '0 : cy + Y_BITS'(1);
                        end else begin
                            cx <= cx + X_BITS'(1);
                        end
                    end
`endif
                end
                RETRY: tries <= tries + TW'(1);
`ifdef FOOD_SPAWNER_SCAN_FALLBACK_EN
                SCAN: begin
                    scanning <= 1'b1;
                    scan_cnt <= '0;
                    if (!have_cand) begin
                        cx <= '0;
                        cy <= '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign o_RandNeed  = (state == REQ);
    assign o_FoodValid = (state == DONE);
    assign o_Fail      = (state == GIVEUP);
    assign o_Busy      = (state != IDLE);
    assign o_OccX      = (state == CHECK || state == EVAL) ? cx : '0;
    assign o_OccY      = (state == CHECK || state == EVAL) ? cy : '0;

endmodule

// File: tb/tb_food_spawner.sv
// Scoreboard bench for food_spawner: LFSR stub with 2-cycle latency, occupancy map model, decoupled result monitor.
module tb_food_spawner;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b0;
    logic        i_Spawn = 1'b0;
    logic        o_RandNeed;
    logic [13:0] i_RandNum = '0;
    logic        i_isRanDone = 1'b0;
    logic [5:0]  o_OccX;
    logic [4:0]  o_OccY;
    logic        i_Occupied = 1'b0;
    logic [5:0]  o_FoodX;
    logic [4:0]  o_FoodY;
    logic        o_FoodValid;
    logic        o_Fail;
    logic        o_Busy;

    food_spawner #(
        .GRID_W(40), .GRID_H(30), .X_BITS(6), .Y_BITS(5), .MAX_TRIES(8)
    ) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Spawn(i_Spawn), .o_RandNeed(o_RandNeed),
        .i_RandNum(i_RandNum), .i_isRanDone(i_isRanDone), .o_OccX(o_OccX), .o_OccY(o_OccY),
        .i_Occupied(i_Occupied), .o_FoodX(o_FoodX), .o_FoodY(o_FoodY),
        .o_FoodValid(o_FoodValid), .o_Fail(o_Fail), .o_Busy(o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int spawn_cyc = 0;
    always @(posedge i_Clk) cyc++;

    typedef struct {
        bit fail;
        int x;
        int y;
        int lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // LFSR stub and occupancy model, all driven on the falling edge
    logic [13:0] rn_q[$];
    logic [13:0] rn_default = 14'h0145;
    int  pend = 0;
    int  n_need = 0, n_b2b = 0, n_overlap = 0;
    bit  prev_need = 0, strobed = 0;
    int  log_x[$], log_y[$];
    bit  occ [0:63][0:31];

    always @(negedge i_Clk) begin
        if (strobed) begin
            log_x.push_back(int'(o_OccX));
            log_y.push_back(int'(o_OccY));
        end
        strobed = 0;
        i_isRanDone = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                i_isRanDone = 1'b1;
                strobed = 1;
                if (rn_q.size() != 0) i_RandNum = rn_q.pop_front();
                else                  i_RandNum = rn_default;
            end
        end
        if (o_RandNeed) begin
            n_need++;
            if (prev_need) n_b2b++;
            if (pend > 0)  n_overlap++;
            pend = 2;
        end
        prev_need = o_RandNeed;
        i_Occupied = occ[o_OccX][o_OccY];
    end

    // Result monitor
    always @(negedge i_Clk) begin
        if (o_FoodValid || o_Fail) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", int'(o_FoodValid) + 2 * int'(o_Fail), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_fail", int'(o_Fail), int'(e.fail));
                chk("result_valid", int'(o_FoodValid), int'(!e.fail));
                if (!e.fail) begin
                    chk("food_x", int'(o_FoodX), e.x);
                    chk("food_y", int'(o_FoodY), e.y);
                end
                if (e.lat != 0) chk("latency", cyc - spawn_cyc, e.lat);
            end
        end
    end

    task automatic pulse_spawn();
        @(negedge i_Clk);
        i_Spawn = 1'b1;
        spawn_cyc = cyc;
        @(negedge i_Clk);
        i_Spawn = 1'b0;
    endtask

    task automatic expect_res(input bit f, input int x, input int y, input int lat);
        exp_t e;
        e.fail = f; e.x = x; e.y = y; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (o_Busy && k < budget) begin
            @(negedge i_Clk);
            k++;
        end
        if (o_Busy) chk("busy_timeout", k, -1);
        repeat (3) @(negedge i_Clk);
    endtask

    task automatic set_occ(input bit v);
        for (int xi = 0; xi < 64; xi++)
            for (int yi = 0; yi < 32; yi++)
                occ[xi][yi] = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(o_Busy), 0);
        chk({tag, "_randneed"}, int'(o_RandNeed), 0);
        chk({tag, "_valid"}, int'(o_FoodValid), 0);
        chk({tag, "_fail"}, int'(o_Fail), 0);
        chk({tag, "_foodx"}, int'(o_FoodX), 0);
        chk({tag, "_foody"}, int'(o_FoodY), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        set_occ(0);
        repeat (3) @(negedge i_Clk);
        chk_all_zero("reset");
        chk("reset_occx", int'(o_OccX), 0);
        chk("reset_occy", int'(o_OccY), 0);
        @(negedge i_Clk);
        i_Rst = 1'b1;
        repeat (2) @(negedge i_Clk);

        // Best case: (5,5), latency 6, busy t+1..t+6
        rn_q.push_back(14'h0145);
        expect_res(0, 5, 5, 6);
        n0 = n_need;
        pulse_spawn();
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) @(negedge i_Clk);
            chk("busy_window", int'(o_Busy), (k <= 6) ? 1 : 0);
        end
        repeat (3) @(negedge i_Clk);
        chk("t1_needs", n_need - n0, 1);
        chk("t1_drained", sb.size(), 0);

        // Out-of-range x=45, then (3,2)
        rn_q.push_back(14'd45);
        rn_q.push_back(14'h0083);
        expect_res(0, 3, 2, 0);
        n0 = n_need;
        pulse_spawn();
        wait_idle(100);
        chk("t2_needs", n_need - n0, 2);
        chk("t2_drained", sb.size(), 0);

        // (3,2) occupied, then (7,9) free
        occ[3][2] = 1;
        log_x.delete();
        log_y.delete();
        rn_q.push_back(14'h0083);
        rn_q.push_back(14'h0247);
        expect_res(0, 7, 9, 0);
        n0 = n_need;
        pulse_spawn();
        wait_idle(100);
        occ[3][2] = 0;
        chk("t3_needs", n_need - n0, 2);
        chk("t3_log_len", log_x.size(), 2);
        if (log_x.size() == 2) begin
            chk("t3_occx0", log_x[0], 3);
            chk("t3_occy0", log_y[0], 2);
            chk("t3_occx1", log_x[1], 7);
            chk("t3_occy1", log_y[1], 9);
        end
        chk("t3_drained", sb.size(), 0);

        // Everything occupied: 8 requests, then fail, food keeps (7,9)
        set_occ(1);
        rn_default = 14'h0083;
        expect_res(1, 0, 0, 0);
        n0 = n_need;
        pulse_spawn();
        wait_idle(4000);
        chk("t4_needs", n_need - n0, 8);
        chk("t4_keep_x", int'(o_FoodX), 7);
        chk("t4_keep_y", int'(o_FoodY), 9);
        chk("t4_drained", sb.size(), 0);

`ifdef FOOD_SPAWNER_SCAN_FALLBACK_EN
        // Scan from (39,29) wraps to the only free cell (0,0)
        set_occ(1);
        occ[0][0] = 0;
        rn_default = 14'h0767;
        expect_res(0, 0, 0, 0);
        n0 = n_need;
        pulse_spawn();
        wait_idle(4000);
        chk("t5_needs", n_need - n0, 8);
        chk("t5_drained", sb.size(), 0);
`endif
        set_occ(0);
        rn_default = 14'h0145;

        // Reset during WAIT_RN, stray done strobe arrives after release
        rn_q.push_back(14'h0145);
        pulse_spawn();
        @(negedge i_Clk);
        chk("t6_busy_before_rst", int'(o_Busy), 1);
        i_Rst = 1'b0;
        #1;
        chk_all_zero("t6_in_reset");
        @(negedge i_Clk);
        i_Rst = 1'b1;
        repeat (10) @(negedge i_Clk);
        chk_all_zero("t6_after");
        chk("t6_drained", sb.size(), 0);

        // Spawn while busy and during the DONE cycle are dropped
        rn_q.push_back(14'h0041);
        expect_res(0, 1, 1, 6);
        n0 = n_need;
        pulse_spawn();
        repeat (2) @(negedge i_Clk);
        i_Spawn = 1'b1;
        @(negedge i_Clk);
        i_Spawn = 1'b0;
        repeat (2) @(negedge i_Clk);
        i_Spawn = 1'b1;
        @(negedge i_Clk);
        i_Spawn = 1'b0;
        chk("t7_idle_after_done", int'(o_Busy), 0);
        repeat (20) @(negedge i_Clk);
        chk("t7_needs", n_need - n0, 1);
        chk("t7_drained", sb.size(), 0);

        chk("randneed_back2back", n_b2b, 0);
        chk("randneed_overlap", n_overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
